// File: rtl/subch_request_scheduler_pkg.sv
// Shared types for the subchannel request scheduler: FSM states, lane modes
// and an index-width helper that stays legal for single-entry vectors.
package subch_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } sched_state_t;

    typedef enum logic {
        MODE_INDEP  = 1'b0,
        MODE_GANGED = 1'b1
    } mode_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/subch_request_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping modulo N. Purely combinational; the caller owns the pointer.
module rr_arbiter
    import subch_sched_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    logic [IW:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(N)) begin
                idx = idx - (IW+1)'(N);
            end
            if (!any_grant && req[idx[IW-1:0]]) begin
                any_grant             = 1'b1;
                grant_idx             = idx[IW-1:0];
                grant[idx[IW-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/subch_request_scheduler.sv
// Subchannel request scheduler: routes requester beats onto independent or
// ganged subchannels under per-subchannel credit flow control.
module subch_request_scheduler
    import subch_sched_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int NUM_SUBCHANNELS  = 2,
    parameter int SUBCHANNEL_WIDTH = 40,
    parameter int DATA_WIDTH       = 80,
    parameter int CREDIT_MAX       = 8,
    localparam int SW = idx_w(NUM_SUBCHANNELS),
    localparam int RW = idx_w(NUM_REQ),
    localparam int CW = $clog2(CREDIT_MAX + 1)
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              cfg_ganged,
    input  logic [NUM_SUBCHANNELS-1:0]                        cfg_subchannel_en,
    input  logic [NUM_REQ-1:0]                                req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]                req_data,
    input  logic [NUM_REQ-1:0][SW-1:0]                        req_subch,
    output logic [NUM_REQ-1:0]                                req_ready,
    output logic [NUM_SUBCHANNELS-1:0]                        sc_valid,
    output logic [NUM_SUBCHANNELS-1:0][SUBCHANNEL_WIDTH-1:0]  sc_data,
    input  logic [NUM_SUBCHANNELS-1:0]                        sc_credit_return,
    output logic                                              busy,
    output logic                                              err_disabled_target,
    output logic                                              err_credit_overflow
);

    sched_state_t state_q, state_d;
    mode_t        mode_q, mode_d, cfg_mode;

    logic [NUM_SUBCHANNELS-1:0][CW-1:0]               credit_q, credit_d;
    logic [NUM_SUBCHANNELS-1:0][RW-1:0]               ptr_q, ptr_d;
    logic [RW-1:0]                                    gptr_q, gptr_d;
    logic [NUM_SUBCHANNELS-1:0]                       sc_valid_q, sc_valid_d;
    logic [NUM_SUBCHANNELS-1:0][SUBCHANNEL_WIDTH-1:0] sc_data_q, sc_data_d;
    logic                                             err_dis_q, err_dis_d;
    logic                                             err_ovf_q, err_ovf_d;

    logic                                             arb_en, gang_en, all_full;
    logic [NUM_SUBCHANNELS-1:0]                       cred_ok;
    logic [NUM_REQ-1:0]                               tgt_en, drop;
    logic [NUM_SUBCHANNELS-1:0][NUM_REQ-1:0]          sub_req, sub_gnt;
    logic [NUM_SUBCHANNELS-1:0][RW-1:0]               sub_idx;
    logic [NUM_SUBCHANNELS-1:0]                       sub_any;
    logic [NUM_REQ-1:0]                               gang_req, gang_gnt;
    logic [RW-1:0]                                    gang_idx;
    logic                                             gang_any;

    function automatic logic [RW-1:0] rr_next(input logic [RW-1:0] i);
        return (i == RW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    assign cfg_mode = cfg_ganged ? MODE_GANGED : MODE_INDEP;
    // A pending mode change blocks grants immediately, even before DRAIN is entered.
    assign arb_en   = !rst && (state_q == ST_ACTIVE) && (cfg_mode == mode_q);
    assign gang_en  = cfg_subchannel_en[0] && cfg_subchannel_en[1];

    always_comb begin
        cred_ok  = '0;
        all_full = 1'b1;
        for (int s = 0; s < NUM_SUBCHANNELS; s++) begin
            cred_ok[s] = (credit_q[s] != '0);
            if (credit_q[s] != CW'(CREDIT_MAX)) begin
                all_full = 1'b0;
            end
        end
    end

    always_comb begin
        tgt_en = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tgt_en[i] = (int'(req_subch[i]) < NUM_SUBCHANNELS) && cfg_subchannel_en[req_subch[i]];
        end
    end

    always_comb begin
        sub_req = '0;
        for (int s = 0; s < NUM_SUBCHANNELS; s++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                sub_req[s][i] = arb_en && (mode_q == MODE_INDEP) && req_valid[i]
                                && (req_subch[i] == SW'(s)) && cfg_subchannel_en[s] && cred_ok[s];
            end
        end
    end

    assign gang_req = (arb_en && (mode_q == MODE_GANGED) && gang_en && cred_ok[0] && cred_ok[1])
                      ? req_valid : '0;

    for (genvar s = 0; s < NUM_SUBCHANNELS; s++) begin : g_sub
        rr_arbiter #(.N(NUM_REQ)) u_arb (
            .req       (sub_req[s]),
            .ptr       (ptr_q[s]),
            .grant     (sub_gnt[s]),
            .grant_idx (sub_idx[s]),
            .any_grant (sub_any[s])
        );
    end

    rr_arbiter #(.N(NUM_REQ)) u_gang_arb (
        .req       (gang_req),
        .ptr       (gptr_q),
        .grant     (gang_gnt),
        .grant_idx (gang_idx),
        .any_grant (gang_any)
    );

    // Grant/transfer path; disabled targets are acked and dropped without arbitration.
    always_comb begin
        req_ready  = '0;
        drop       = '0;
        sc_valid_d = '0;
        sc_data_d  = sc_data_q;
        ptr_d      = ptr_q;
        gptr_d     = gptr_q;
        if (arb_en) begin
            if (mode_q == MODE_GANGED) begin
                if (!gang_en) begin
                    req_ready = req_valid;
                    drop      = req_valid;
                end else if (gang_any) begin
                    req_ready       = gang_gnt;
                    sc_valid_d[1:0] = 2'b11;
                    sc_data_d[0]    = req_data[gang_idx][SUBCHANNEL_WIDTH-1:0];
                    sc_data_d[1]    = req_data[gang_idx][DATA_WIDTH-1:SUBCHANNEL_WIDTH];
                    gptr_d          = rr_next(gang_idx);
                end
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && !tgt_en[i]) begin
                        req_ready[i] = 1'b1;
                        drop[i]      = 1'b1;
                    end
                end
                for (int s = 0; s < NUM_SUBCHANNELS; s++) begin
                    if (sub_any[s]) begin
                        req_ready     = req_ready | sub_gnt[s];
                        sc_valid_d[s] = 1'b1;
                        sc_data_d[s]  = req_data[sub_idx[s]][SUBCHANNEL_WIDTH-1:0];
                        ptr_d[s]      = rr_next(sub_idx[s]);
                    end
                end
            end
        end
    end

    always_comb begin
        credit_d  = credit_q;
        err_ovf_d = err_ovf_q;
        err_dis_d = err_dis_q | (|drop);
        for (int s = 0; s < NUM_SUBCHANNELS; s++) begin
            case ({sc_valid_d[s], sc_credit_return[s]})
                2'b10: credit_d[s] = credit_q[s] - 1'b1;
                2'b01: begin
                    if (credit_q[s] == CW'(CREDIT_MAX)) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        credit_d[s] = credit_q[s] + 1'b1;
                    end
                end
                default: credit_d[s] = credit_q[s];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (cfg_mode != mode_q)           state_d = ST_DRAIN;
                else if (!(|req_valid) && all_full) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (all_full) begin
                    state_d = ST_IDLE;
                    mode_d  = cfg_mode;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= cfg_mode;
            gptr_q     <= '0;
            sc_valid_q <= '0;
            sc_data_q  <= '0;
            err_dis_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            for (int s = 0; s < NUM_SUBCHANNELS; s++) begin
                credit_q[s] <= CW'(CREDIT_MAX);
                ptr_q[s]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            credit_q   <= credit_d;
            ptr_q      <= ptr_d;
            gptr_q     <= gptr_d;
            sc_valid_q <= sc_valid_d;
            sc_data_q  <= sc_data_d;
            err_dis_q  <= err_dis_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    assign sc_valid            = sc_valid_q;
    assign sc_data             = sc_data_q;
    assign busy                = (state_q != ST_IDLE);
    assign err_disabled_target = err_dis_q;
    assign err_credit_overflow = err_ovf_q;

endmodule

// File: doc/subch_request_scheduler.md
SUBCH_REQUEST_SCHEDULER -- requirements
Module: subch_request_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters.
REQ-002 Parameter NUM_SUBCHANNELS, default 2: number of subchannels; ganged mode uses subchannels 0 and 1.
REQ-003 Parameter SUBCHANNEL_WIDTH, default 40: width of each subchannel data bus.
REQ-004 Parameter DATA_WIDTH, default 80: requester data width, equal to 2*SUBCHANNEL_WIDTH.
REQ-005 Parameter CREDIT_MAX, default 8: credits per subchannel.
REQ-006 Ports shall be as follows; the block has one clock, and reset is synchronous and active-high:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_ganged  in  1  1 = ganged mode, 0 = independent mode.
- cfg_subchannel_en  in  NUM_SUBCHANNELS  per-subchannel enable.
- req_valid  in  NUM_REQ  request valid.
- req_data  in  NUM_REQ x DATA_WIDTH  request payload.
- req_subch  in  NUM_REQ x $clog2(NUM_SUBCHANNELS)  target subchannel; ignored in ganged mode.
- req_ready  out  NUM_REQ  request accepted this cycle.
- sc_valid  out  NUM_SUBCHANNELS  registered subchannel beat valid.
- sc_data  out  NUM_SUBCHANNELS x SUBCHANNEL_WIDTH  registered subchannel payload.
- sc_credit_return  in  NUM_SUBCHANNELS  one credit returned per pulse.
- busy  out  1  state is not IDLE.
- err_disabled_target  out  1  sticky: a request to a disabled subchannel was dropped.
- err_credit_overflow  out  1  sticky: a credit was returned while the counter was at CREDIT_MAX.

Function
REQ-007 States: IDLE, ACTIVE, DRAIN.
- IDLE->ACTIVE: any req_valid is high.
- ACTIVE->IDLE: no req_valid is high and all credit counters equal CREDIT_MAX.
- ACTIVE->DRAIN: cfg_ganged differs from the latched mode.
- DRAIN->IDLE: all credit counters equal CREDIT_MAX; the new mode is latched on this transition.
REQ-008 Grants shall be issued only in ACTIVE; req_ready is combinational in the same cycle as the grant, and a transfer occurs when req_valid & req_ready.
REQ-009 Independent mode: each subchannel has its own round-robin arbiter over requesters whose req_subch targets it; at most one grant per subchannel per cycle, and up to NUM_SUBCHANNELS grants total per cycle.
REQ-010 Independent transfer: sc_data[s] <= req_data[SUBCHANNEL_WIDTH-1:0]; sc_valid[s] is high in the next cycle (latency 1); one credit of subchannel s is consumed.
REQ-011 Ganged mode: a single round-robin arbiter; a grant requires credit >= 1 on both subchannel 0 and subchannel 1.
REQ-012 Ganged transfer: sc_data[0] <= data[39:0] and sc_data[1] <= data[79:40] in the same cycle; both sc_valid are high together; one credit is consumed from each subchannel.
REQ-013 A subchannel whose credit counter is 0 shall receive no grant; requesters targeting it see req_ready = 0 and hold their request.
REQ-014 A request to a disabled target (independent mode), or any ganged request while either subchannel is disabled, shall be accepted (req_ready = 1) and dropped; no sc_valid and no credit consumed; err_disabled_target is set.
REQ-015 Round-robin pointer: advances to granted index + 1 (mod NUM_REQ) only on a transfer; the search starts at the pointer; the pointer is unchanged when there is no transfer.
REQ-016 Credit counters are $clog2(CREDIT_MAX+1) bits wide.
- Simultaneous consume and return: counter unchanged.
- Return at CREDIT_MAX: counter saturates and err_credit_overflow is set.
- A counter shall never go below 0.
REQ-017 sc_valid deasserts in the cycle after the last transfer; sc_data holds its last value while sc_valid = 0.
REQ-018 Changes to cfg_subchannel_en take effect on the next arbitration cycle and do not trigger DRAIN.

Reset
REQ-019 While rst is high at a clock edge, the following reset values shall apply:
- State = IDLE.
- Credits = CREDIT_MAX.
- Round-robin pointers = 0.
- sc_valid = 0, sc_data = 0, req_ready = 0, busy = 0.
- Both error flags = 0.
- Latched mode = cfg_ganged.
REQ-020 Reset asserted mid-transfer shall discard in-flight beats; no sc_valid shall be asserted in the cycle after the reset edge.

Structure
REQ-021 Package subch_sched_pkg shall hold the state enum sched_state_t and a mode enum (MODE_INDEP, MODE_GANGED).
REQ-022 Sub-module rr_arbiter (parameter N; ports: req vector, pointer, grant one-hot, grant index, any_grant) shall be instantiated once per subchannel plus once for ganged mode.

Verification
REQ-023 Reset, then independent mode, requesters 0 and 2 both targeting subchannel 0 on every cycle -> grants alternate 0,2,0,2; sc_valid[0] high 1 cycle after each transfer.
REQ-024 Independent mode, credits exhausted on subchannel 1 after 8 transfers with no returns -> req_ready = 0 for subchannel-1 requesters; one sc_credit_return[1] pulse -> exactly one further grant.
REQ-025 Ganged mode, req_data = 80'h12345_67890_ABCDE_F0123 on requester 3 -> sc_data[0] = 40'hABCDEF0123, sc_data[1] = 40'h1234567890 in the same cycle; both credits decrement by 1.
REQ-026 Toggle cfg_ganged while 3 credits are outstanding -> state DRAIN, no grants; after 3 returns -> IDLE, then ACTIVE in the new mode.
REQ-027 cfg_subchannel_en = 2'b01, request to subchannel 1 -> req_ready = 1, no sc_valid, err_disabled_target = 1; return on subchannel 0 at credit 8 -> err_credit_overflow = 1, counter stays at 8.
